vga_timing: RTL and testbench
=============================

# vga_timing

Generates the 640x480@60 raster for the display pipeline. It drives the pixel coordinates `x_px`/`y_px` consumed by the overlay renderers (numbers, trace, grid) and receives their `color_px` result. It re-aligns sync and blanking to the renderers' fixed pipeline latency and emits the final `hsync`/`vsync`/`rgb` to the DAC pins.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: hsync pulse width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync`
- `LATENCY`, 2: clocks from `x_px`/`y_px` to the matching `color_px`; range 0..7

Ports:
- `clk`  in  1  pixel clock, 25.175 MHz nominal
- `reset_n`  in  1  asynchronous, active-low reset
- `color_px`  in  6  renderer pixel colour {R[1:0],G[1:0],B[1:0]}, valid `LATENCY` clocks after its coordinates
- `x_px`  out  10  horizontal counter, 0..H_TOTAL-1
- `y_px`  out  10  vertical counter, 0..V_TOTAL-1
- `active`  out  1  (`x_px` < H_ACTIVE) && (`y_px` < V_ACTIVE), aligned with `x_px`/`y_px`
- `frame_start`  out  1  one-clock pulse when the counters are at (0,0)
- `hsync`  out  1  registered horizontal sync to pin
- `vsync`  out  1  registered vertical sync to pin
- `rgb`  out  6  registered pixel colour to pin; 0 during blanking

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- `x_px` increments every clock. At H_TOTAL-1 it wraps to 0 and `y_px` increments. `y_px` wraps from V_TOTAL-1 to 0 on the same clock that `x_px` wraps.
- Undelayed sync decode:
  - hs_raw = `x_px` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
  - vs_raw = `y_px` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [490,492), for the whole line.
- hs_raw, vs_raw and `active` each pass through a `LATENCY`-stage shift register. The delayed flags are then used in a final output register:
  - `hsync` = hs_d ? SYNC_POL : ~SYNC_POL
  - `vsync` = vs_d ? SYNC_POL : ~SYNC_POL
  - `rgb` = act_d ? `color_px` : 0
- When `LATENCY`=0, the shift registers are bypassed and only the output register remains.
- `frame_start` = (`x_px`==0 && `y_px`==0) && started. The `started` flag is set on the first clock after `reset_n` rises and is never cleared except by reset. As a result, no `frame_start` pulse occurs for the post-reset (0,0) position. The first pulse comes at the first wrap.
- The block has no back-pressure. `color_px` is sampled unconditionally every clock.

## Timing
Reset values while `reset_n`=0:

| Output | Reset value |
|---|---|
| `x_px`, `y_px` | 0 |
| `active` | 1 (combinational decode of (0,0)) |
| `frame_start` | 0 |
| `hsync`, `vsync` | ~SYNC_POL |
| `rgb` | 0 |
| delay stages | 0 (inactive) |

- Reset is asynchronous: assertion takes effect immediately. Deassertion is synchronised externally.
- The first rising edge after release moves the counters to (1,0).
- Total latency from a counter value to the pin outputs is `LATENCY`+1 clocks. The `rgb` value at clock t+LATENCY+1 equals the `color_px` value sampled at t+LATENCY for the coordinates presented at t.
- Reset mid-frame restarts the raster at (0,0). The delay lines flush to blank, so no partial sync pulse is carried across the reset.
- Line period is 800 clocks. Frame period is 420000 clocks.
- `hsync` is asserted for 96 clocks per line. `vsync` is asserted for 1600 clocks per frame.

## Structure
- A shared package `vga_pkg` holds:
  - the timing defaults and derived H_TOTAL/V_TOTAL;
  - the 6-bit colour constants (black, blue, green, red, yellow, white) also used by the renderers;
  - the `color_t` 6-bit typedef.
- Sub-module `delay_line` (parameters WIDTH, DEPTH; async active-low reset to 0) is instantiated once with WIDTH=3 for {hs, vs, active}.
- Counters and sync decode live in the top module.

## Test plan
- Free run 2 frames, `LATENCY`=2: `x_px` wraps 799→0 and `y_px` 524→0 on the same clock; `frame_start` is high exactly once per 420000 clocks.
- Line check: `hsync` is 0 for exactly 96 clocks, starting 3 clocks after `x_px`=656; `vsync` is 0 from line 490 to 491 (delayed by 3 clocks).
- Latency: drive `color_px` = `x_px`[5:0] delayed 2 clocks → at `rgb` the pixel at x=37 reads 6'd37, and x=639 reads 6'd63 (639 mod 64); x=640..799 read 0.
- Blanking: hold `color_px`=6'b111111 → `rgb`=0 on every clock whose delayed `active` is 0, including lines 480..524.
- `LATENCY`=0 build: `rgb` follows `color_px` with 1 clock delay; `hsync` falls 1 clock after `x_px`=656.
- Reset pulse at `x_px`=700, `y_px`=200: outputs go immediately to their reset values; counters restart at (1,0) after release; no `frame_start` until the next (0,0) wrap 420000 clocks later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, colour type and palette for the VGA display pipeline.
// The renderers import the same palette so the colours on screen stay consistent.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // {R[1:0], G[1:0], B[1:0]}
    typedef logic [5:0] color_t;

    localparam color_t COLOR_BLACK  = 6'b00_00_00;
    localparam color_t COLOR_BLUE   = 6'b00_00_11;
    localparam color_t COLOR_GREEN  = 6'b00_11_00;
    localparam color_t COLOR_RED    = 6'b11_00_00;
    localparam color_t COLOR_YELLOW = 6'b11_11_00;
    localparam color_t COLOR_WHITE  = 6'b11_11_11;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with asynchronous clear; DEPTH of 0 is a straight wire.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset_n;
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 raster generator: pixel counters for the renderers, then sync/blank
// re-aligned to the renderer pipeline latency and registered onto the DAC pins.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned LATENCY  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] color_px,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       active,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       started_q;
    logic       hs_raw, vs_raw;
    logic [2:0] flags_raw, flags_dly;
    logic       hsync_q, vsync_q;
    color_t     rgb_q;

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == 10'(H_TOTAL - 1)) begin
            x_d = '0;
            y_d = (y_q == 10'(V_TOTAL - 1)) ? '0 : y_q + 10'd1;
        end
    end

    // started_q suppresses the frame_start pulse for the (0,0) position held during reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            started_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            started_q <= 1'b1;
        end
    end

    assign active = (x_q < 10'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
    assign hs_raw = (x_q >= 10'(HS_START)) && (x_q < 10'(HS_END));
    assign vs_raw = (y_q >= 10'(VS_START)) && (y_q < 10'(VS_END));

    assign x_px        = x_q;
    assign y_px        = y_q;
    assign frame_start = (x_q == '0) && (y_q == '0) && started_q;

    assign flags_raw = {hs_raw, vs_raw, active};

    delay_line #(
        .WIDTH(3),
        .DEPTH(LATENCY)
    ) u_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (flags_raw),
        .dout   (flags_dly)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            rgb_q   <= COLOR_BLACK;
        end else begin
            hsync_q <= flags_dly[2] ? SYNC_POL : ~SYNC_POL;
            vsync_q <= flags_dly[1] ? SYNC_POL : ~SYNC_POL;
            rgb_q   <= flags_dly[0] ? color_t'(color_px) : COLOR_BLACK;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: full-size, short-frame and zero-latency builds
// checked every clock against a raster model, plus hand-computed spot values.
module tb_vga_timing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
    } exp_t;

    typedef struct packed {
        int   kk;
        int   seg;
        exp_t f;
        exp_t s;
        exp_t z;
    } ent_t;

    localparam int RST_KK = 23900;  // small build at (700,3) in its third frame
    localparam int END_KK = 10450;

    logic       clk;
    logic       reset_n;
    logic [5:0] color_px;

    logic [9:0] f_x, f_y, s_x, s_y, z_x, z_y;
    logic       f_act, f_fs, f_hs, f_vs;
    logic       s_act, s_fs, s_hs, s_vs;
    logic       z_act, z_fs, z_hs, z_vs;
    logic [5:0] f_rgb, s_rgb, z_rgb;

    ent_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   s_fs_cnt0 = 0, s_fs_cnt1 = 0, f_fs_cnt = 0;
    int   f_hs_low = 0, s_vs_low = 0;
    int   done = 0;

    vga_timing u_full (
        .clk(clk), .reset_n(reset_n), .color_px(color_px),
        .x_px(f_x), .y_px(f_y), .active(f_act), .frame_start(f_fs),
        .hsync(f_hs), .vsync(f_vs), .rgb(f_rgb)
    );

    vga_timing #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .color_px(color_px),
        .x_px(s_x), .y_px(s_y), .active(s_act), .frame_start(s_fs),
        .hsync(s_hs), .vsync(s_vs), .rgb(s_rgb)
    );

    vga_timing #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .LATENCY(0)
    ) u_zero (
        .clk(clk), .reset_n(reset_n), .color_px(color_px),
        .x_px(z_x), .y_px(z_y), .active(z_act), .frame_start(z_fs),
        .hsync(z_hs), .vsync(z_vs), .rgb(z_rgb)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Expected outputs k edges after reset release; col is the colour captured at edge k.
    function automatic exp_t model(int k, int va, int vs0, int vt, int lat, logic [5:0] col);
        exp_t e;
        int   frame, p, j, pj, xj, yj;
        logic hsd, vsd, actd;
        frame = 800 * vt;
        p     = k % frame;
        e.x   = 10'(p % 800);
        e.y   = 10'(p / 800);
        e.act = ((p % 800) < 640) && ((p / 800) < va);
        e.fs  = (p == 0) && (k > 0);
        hsd = 1'b0;
        vsd = 1'b0;
        actd = 1'b0;
        j = k - 1 - lat;
        if (j >= 0) begin
            pj   = j % frame;
            xj   = pj % 800;
            yj   = pj / 800;
            hsd  = (xj >= 656) && (xj < 752);
            vsd  = (yj >= vs0) && (yj < vs0 + 2);
            actd = (xj < 640) && (yj < va);
        end
        e.hs  = ~hsd;
        e.vs  = ~vsd;
        e.rgb = actd ? col : 6'd0;
        return e;
    endfunction

    task automatic spot(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic cmp(string name, int kk, int seg, exp_t got, exp_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s seg=%0d kk=%0d: got x=%0d y=%0d act=%b fs=%b hs=%b vs=%b rgb=%0d, expected x=%0d y=%0d act=%b fs=%b hs=%b vs=%b rgb=%0d",
                     name, seg, kk, got.x, got.y, got.act, got.fs, got.hs, got.vs, got.rgb,
                     want.x, want.y, want.act, want.fs, want.hs, want.vs, want.rgb);
        end
    endtask

    // Stimulus: drive reset/colour just after each rising edge and queue the expected sample.
    initial begin
        ent_t       ent;
        logic [5:0] prev_col;
        int         kk, seg, hold;
        reset_n  = 1'b0;
        color_px = '0;
        prev_col = '0;
        kk = 0;
        seg = 0;
        hold = 2;
        for (int step = 0; step < 40000 && done == 0; step++) begin
            @(posedge clk);
            #1;
            if (reset_n) kk++;
            else kk = 0;
            prev_col = color_px;
            if (seg == 0 && reset_n && kk == RST_KK) begin
                reset_n = 1'b0;
                seg = 1;
                kk = 0;
                hold = 2;
                #1;
                spot("rst_f_x", f_x, 0);
                spot("rst_f_y", f_y, 0);
                spot("rst_f_active", f_act, 1);
                spot("rst_f_rgb", f_rgb, 0);
                spot("rst_s_hsync", s_hs, 1);
                spot("rst_s_x", s_x, 0);
            end else if (!reset_n) begin
                if (hold == 0) reset_n = 1'b1;
                else hold--;
            end
            if (seg == 0 && kk < 12000) color_px = (kk >= 2) ? 6'((kk - 2) % 800) : 6'd0;
            else if (seg == 0 && kk < 20800) color_px = 6'h3f;
            else color_px = 6'($urandom);
            ent.kk  = kk;
            ent.seg = seg;
            ent.f   = model(kk, 480, 490, 525, 2, prev_col);
            ent.s   = model(kk, 6, 8, 13, 2, prev_col);
            ent.z   = model(kk, 6, 8, 13, 0, prev_col);
            sb_q.push_back(ent);
            if (seg == 1 && kk == END_KK) done = 1;
        end
        @(negedge clk);
        #1;
        spot("run_completed", done, 1);
        spot("scoreboard_drained", sb_q.size(), 0);
        spot("s_frame_start_before_reset", s_fs_cnt0, 2);
        spot("s_frame_start_after_reset", s_fs_cnt1, 1);
        spot("f_frame_start_count", f_fs_cnt, 0);
        spot("f_hsync_low_line1", f_hs_low, 96);
        spot("s_vsync_low_frame0", s_vs_low, 1600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: every falling edge presents one sample per build.
    always @(negedge clk) begin : monitor
        ent_t ent;
        exp_t gf, gs, gz;
        if (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            gf = {f_x, f_y, f_act, f_fs, f_hs, f_vs, f_rgb};
            gs = {s_x, s_y, s_act, s_fs, s_hs, s_vs, s_rgb};
            gz = {z_x, z_y, z_act, z_fs, z_hs, z_vs, z_rgb};
            cmp("full", ent.kk, ent.seg, gf, ent.f);
            cmp("small", ent.kk, ent.seg, gs, ent.s);
            cmp("zero_lat", ent.kk, ent.seg, gz, ent.z);

            if (gf.fs) f_fs_cnt++;
            if (gs.fs && ent.seg == 0) s_fs_cnt0++;
            if (gs.fs && ent.seg == 1) s_fs_cnt1++;
            if (ent.seg == 0 && ent.kk >= 800 && ent.kk < 1600 && !gf.hs) f_hs_low++;
            if (ent.seg == 0 && ent.kk < 10400 && !gs.vs) s_vs_low++;

            if (ent.seg == 0) begin
                case (ent.kk)
                    40: begin
                        spot("f_rgb_x37", gf.rgb, 37);
                        spot("z_rgb_x37", gz.rgb, 37);
                    end
                    642: spot("f_rgb_x639", gf.rgb, 63);
                    643: spot("f_rgb_x640_blank", gf.rgb, 0);
                    656: spot("z_hsync_before", gz.hs, 1);
                    657: spot("z_hsync_fall", gz.hs, 0);
                    658: spot("f_hsync_before", gf.hs, 1);
                    659: spot("f_hsync_fall", gf.hs, 0);
                    754: spot("f_hsync_last", gf.hs, 0);
                    755: spot("f_hsync_rise", gf.hs, 1);
                    799: spot("f_x_799", gf.x, 799);
                    800: begin
                        spot("f_x_wrap", gf.x, 0);
                        spot("f_y_incr", gf.y, 1);
                    end
                    802: spot("f_rgb_x799_blank", gf.rgb, 0);
                    840: spot("f_rgb_line1_x37", gf.rgb, 37);
                    6402: spot("s_vsync_before", gs.vs, 1);
                    6403: spot("s_vsync_fall", gs.vs, 0);
                    8002: spot("s_vsync_last", gs.vs, 0);
                    8003: spot("s_vsync_rise", gs.vs, 1);
                    10399: begin
                        spot("s_x_end", gs.x, 799);
                        spot("s_y_end", gs.y, 12);
                    end
                    10400: begin
                        spot("s_x_frame_wrap", gs.x, 0);
                        spot("s_y_frame_wrap", gs.y, 0);
                        spot("s_frame_start", gs.fs, 1);
                    end
                    12103: spot("s_rgb_active_white", gs.rgb, 63);
                    16103: spot("s_rgb_vblank", gs.rgb, 0);
                    default: ;
                endcase
            end else if (ent.kk == 1) begin
                spot("s_restart_x", gs.x, 1);
                spot("s_restart_y", gs.y, 0);
                spot("s_restart_no_fs", gs.fs, 0);
            end
        end
    end

endmodule
